// File: rtl/reg_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: default widths,
// the holding-buffer FSM states and the hard-wired zero register.
package reg_wb_arbiter_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int REG_ZERO   = 0;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    EMPTY,
    HELD,
    STARVE
  } arb_state_e;

endpackage

// File: rtl/wb_hold_buf.sv
// One-entry holding register for an aux result that lost the write port.
// Drain has priority; capture is only ever requested while the entry is empty.
module wb_hold_buf
  import reg_wb_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture,
  input  logic [ADDR_W-1:0] cap_reg,
  input  logic [DATA_W-1:0] cap_data,
  input  logic              drain,
  output logic              full,
  output logic [ADDR_W-1:0] buf_reg,
  output logic [DATA_W-1:0] buf_data,
  output logic [ADDR_W-1:0] pend_reg
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= 1'b0;
      buf_reg  <= '0;
      buf_data <= '0;
    end else if (drain) begin
      full <= 1'b0;
    end else if (capture) begin
      full     <= 1'b1;
      buf_reg  <= cap_reg;
      buf_data <= cap_data;
    end
  end

  // Decode compares against pend_reg, so hide the stale address once drained.
  assign pend_reg = full ? buf_reg : '0;

endmodule

// File: rtl/reg_wb_arbiter.sv
// Arbitrates the register file's single write port between the fixed-timing
// pipeline writeback (always wins) and the handshaked aux unit.
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p_valid,
  input  logic [ADDR_W-1:0] p_reg,
  input  logic [DATA_W-1:0] p_data,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  output logic              regwrite,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              pend_valid,
  output logic [ADDR_W-1:0] pend_reg,
  output logic              stall_req
);

  logic              pipe_req;
  logic              aux_req;
  logic              buf_full;
  logic              capture;
  logic              drain;
  logic [ADDR_W-1:0] buf_reg;
  logic [DATA_W-1:0] buf_data;
  arb_state_e        state;
  arb_state_e        state_next;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  wait_next;

  // Writes to r0 are null: they complete their handshake but never use the port.
  assign pipe_req = p_valid & (p_reg != ADDR_W'(REG_ZERO));
  assign aux_req  = a_valid & (a_reg != ADDR_W'(REG_ZERO));
  assign a_ready  = !buf_full;
  assign capture  = aux_req & a_ready & pipe_req;
  assign drain    = !pipe_req & buf_full;

  wb_hold_buf #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_hold_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .capture  (capture),
    .cap_reg  (a_reg),
    .cap_data (a_data),
    .drain    (drain),
    .full     (buf_full),
    .buf_reg  (buf_reg),
    .buf_data (buf_data),
    .pend_reg (pend_reg)
  );

  assign pend_valid = buf_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite   <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else if (pipe_req) begin
      regwrite   <= 1'b1;
      write_reg  <= p_reg;
      write_data <= p_data;
    end else if (buf_full) begin
      regwrite   <= 1'b1;
      write_reg  <= buf_reg;
      write_data <= buf_data;
    end else if (aux_req) begin
      regwrite   <= 1'b1;
      write_reg  <= a_reg;
      write_data <= a_data;
    end else begin
      regwrite <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
    end
  end

  // STARVE is entered on the same edge the counter reaches MAX_WAIT.
  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    case (state)
      EMPTY: begin
        wait_next = '0;
        if (capture) state_next = HELD;
      end
      HELD, STARVE: begin
        if (drain) begin
          state_next = EMPTY;
          wait_next  = '0;
        end else begin
          if (wait_cnt != CNT_W'(MAX_WAIT)) wait_next = wait_cnt + CNT_W'(1);
          if (wait_next == CNT_W'(MAX_WAIT)) state_next = STARVE;
        end
      end
      default: begin
        state_next = EMPTY;
        wait_next  = '0;
      end
    endcase
  end

  assign stall_req = (state == STARVE);

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Scoreboard bench for reg_wb_arbiter: directed scenarios then random traffic,
// with a behavioural model predicting every register-file write.
module tb_reg_wb_arbiter;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              p_valid = 1'b0;
  logic [ADDR_W-1:0] p_reg = '0;
  logic [DATA_W-1:0] p_data = '0;
  logic              a_valid = 1'b0;
  logic              a_ready;
  logic [ADDR_W-1:0] a_reg = '0;
  logic [DATA_W-1:0] a_data = '0;
  logic              regwrite;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_reg;
  logic              stall_req;

  reg_wb_arbiter #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .p_valid   (p_valid),
    .p_reg     (p_reg),
    .p_data    (p_data),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_reg     (a_reg),
    .a_data    (a_data),
    .regwrite  (regwrite),
    .write_reg (write_reg),
    .write_data(write_data),
    .pend_valid(pend_valid),
    .pend_reg  (pend_reg),
    .stall_req (stall_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_pass = 0;

  // Reference model: a one-slot mailbox plus how many edges it has waited.
  bit                m_held = 1'b0;
  logic [ADDR_W-1:0] m_reg = '0;
  logic [DATA_W-1:0] m_data = '0;
  int                m_waited = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic checkOutput();
    check("a_ready", 32'(a_ready), 32'(!m_held));
    check("pend_valid", 32'(pend_valid), 32'(m_held));
    check("pend_reg", 32'(pend_reg), m_held ? 32'(m_reg) : 32'd0);
    check("stall_req", 32'(stall_req), 32'(m_held && m_waited >= MAX_WAIT));
  endtask

  task automatic modelStep();
    bit pipe;
    bit aux;
    pipe = p_valid && (p_reg != 0);
    aux  = a_valid && (a_reg != 0);
    if (pipe) exp_q.push_back('{r: p_reg, d: p_data});
    else if (m_held) exp_q.push_back('{r: m_reg, d: m_data});
    else if (aux) exp_q.push_back('{r: a_reg, d: a_data});
    if (m_held) begin
      if (!pipe) begin
        m_held   = 1'b0;
        m_waited = 0;
      end else if (m_waited < MAX_WAIT) begin
        m_waited++;
      end
    end else if (pipe && aux) begin
      m_held   = 1'b1;
      m_reg    = a_reg;
      m_data   = a_data;
      m_waited = 0;
    end
  endtask

  task automatic applyStimulus(input bit pv, input logic [ADDR_W-1:0] pr, input logic [DATA_W-1:0] pd,
                               input bit av, input logic [ADDR_W-1:0] ar, input logic [DATA_W-1:0] ad);
    @(negedge clk);
    #1;
    checkOutput();
    p_valid = pv;
    p_reg   = pr;
    p_data  = pd;
    a_valid = av;
    a_reg   = ar;
    a_data  = ad;
    modelStep();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  task automatic asyncReset();
    @(negedge clk);
    #1;
    checkOutput();
    p_valid = 1'b0;
    a_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_regwrite", 32'(regwrite), 32'd0);
    check("rst_pend_valid", 32'(pend_valid), 32'd0);
    check("rst_stall_req", 32'(stall_req), 32'd0);
    check("rst_a_ready", 32'(a_ready), 32'd1);
    exp_q.delete();
    m_held   = 1'b0;
    m_waited = 0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every write the DUT presents must match the oldest expectation.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (regwrite === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_regwrite", 32'(regwrite), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("write_reg", 32'(write_reg), 32'(e.r));
          check("write_data", write_data, e.d);
        end
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("missing_regwrite", 32'(regwrite), 32'd1);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: simulation exceeded time budget");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit pv;
    repeat (2) @(negedge clk);
    #1;
    check("reset_regwrite", 32'(regwrite), 32'd0);
    check("reset_write_reg", 32'(write_reg), 32'd0);
    check("reset_write_data", write_data, 32'd0);
    checkOutput();
    rst_n = 1'b1;

    $display("[TB] pipeline write");
    applyStimulus(1, 3, 32'hAAAA5555, 0, 0, 0);
    idle(1);

    $display("[TB] aux bypass");
    applyStimulus(0, 0, 0, 1, 7, 32'h12);
    idle(1);

    $display("[TB] collision");
    applyStimulus(1, 4, 32'h4444, 1, 9, 32'h9999);
    applyStimulus(0, 0, 0, 0, 0, 0);
    idle(1);

    $display("[TB] starvation");
    applyStimulus(1, 1, 32'h1111, 1, 6, 32'h6666);
    for (int i = 0; i < 6; i++) applyStimulus(1, 5'(2 + i), 32'($urandom), 0, 0, 0);
    idle(3);

    $display("[TB] null writes");
    applyStimulus(1, 3, 32'h3333, 1, 5, 32'h5555);
    applyStimulus(1, 0, 32'hDEAD, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 32'hBEEF);
    idle(2);

    $display("[TB] async reset while held");
    applyStimulus(1, 4, 32'h4040, 1, 9, 32'h9090);
    asyncReset();
    idle(2);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      if (m_held && m_waited >= MAX_WAIT) pv = ($urandom_range(0, 4) == 0);
      else pv = ($urandom_range(0, 9) < 7);
      applyStimulus(pv, 5'($urandom_range(0, 7)), 32'($urandom),
                    bit'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 32'($urandom));
    end
    idle(4);

    @(negedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
